bc_frame_scheduler: RTL

// - Sequences the shared stochastic-computing FIR datapath: one input sample per frame, one delay-pipeline shift,
//   SC_LEN bitstream cycles on all branch converters, then capture and serialisation of the NUM_BRANCH outputs.
// - Sits between the sample source / sink and the input_ctrl + bc_1..bc_8 branches; owns their enables.

---
 rtl/bc_frame_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bc_frame_scheduler.sv
// Frame sequencer for the shared stochastic-computing FIR datapath: load, SC_LEN-cycle run, capture, serialise.
// Optional macro BC_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module bc_frame_scheduler #(
    parameter int NUM_BRANCH = 8,
    parameter int DATA_W     = 8,
    parameter int SC_LEN     = 256,
    parameter int CHAN_W     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_enable,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_sample,
    output logic [DATA_W-1:0]            pipe_sample,
    output logic                         pipe_shift,
    output logic                         branch_clr,
    output logic                         branch_en,
    input  logic [NUM_BRANCH*DATA_W-1:0] branch_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CHAN_W-1:0]            out_chan,
    output logic                         out_last,
`ifdef BC_FRAME_CNT_EN
    output logic [15:0]                  frame_cnt,
`endif
    output logic                         busy
);

    localparam int CNT_W = (SC_LEN > 1) ? $clog2(SC_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SC_LEN - 1);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(NUM_BRANCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [CHAN_W-1:0]   chan_reg, chan_next;
    logic [DATA_W-1:0]   sample_reg, sample_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                capture;
    logic                in_ready_reg, pipe_shift_reg, branch_clr_reg, branch_en_reg;
    logic                out_valid_reg, out_last_reg, busy_reg;
    logic [DATA_W-1:0]   bank_reg [NUM_BRANCH];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        chan_next   = chan_reg;
        sample_next = sample_reg;
        data_next   = data_reg;
        capture     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    sample_next = in_sample;
                    state_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_next   = '0;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_CAPTURE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Word 0 bypasses the bank so out_data is valid on the first DRAIN cycle.
                capture    = 1'b1;
                chan_next  = '0;
                data_next  = branch_out[DATA_W-1:0];
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (chan_reg == CHAN_LAST) begin
                        chan_next  = '0;
                        state_next = S_IDLE;
                    end else begin
                        chan_next = chan_reg + 1'b1;
                        data_next = bank_reg[chan_reg + 1'b1];
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            chan_reg       <= '0;
            sample_reg     <= '0;
            data_reg       <= '0;
            in_ready_reg   <= 1'b1;
            pipe_shift_reg <= 1'b0;
            branch_clr_reg <= 1'b0;
            branch_en_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else if (clk_enable) begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            chan_reg       <= chan_next;
            sample_reg     <= sample_next;
            data_reg       <= data_next;
            in_ready_reg   <= (state_next == S_IDLE);
            pipe_shift_reg <= (state_next == S_LOAD);
            branch_clr_reg <= (state_next == S_LOAD);
            branch_en_reg  <= (state_next == S_RUN);
            out_valid_reg  <= (state_next == S_DRAIN);
            out_last_reg   <= (state_next == S_DRAIN) && (chan_next == CHAN_LAST);
            busy_reg       <= (state_next != S_IDLE);
        end else begin
            // Pulses fire once on entry to LOAD and stay low while stalled.
            pipe_shift_reg <= 1'b0;
            branch_clr_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (reset) begin
                    bank_reg[gi] <= '0;
                end else if (clk_enable && capture) begin
                    bank_reg[gi] <= branch_out[gi*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

`ifdef BC_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (clk_enable && (state_reg == S_DRAIN) && out_ready && (chan_reg == CHAN_LAST)) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

    assign in_ready    = in_ready_reg;
    assign pipe_sample = sample_reg;
    assign pipe_shift  = pipe_shift_reg;
    assign branch_clr  = branch_clr_reg;
    assign branch_en   = branch_en_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = data_reg;
    assign out_chan    = chan_reg;
    assign out_last    = out_last_reg;
    assign busy        = busy_reg;

endmodule
